// File: rtl/pio_evt_pkg.sv
// Shared definitions for the PIO event master: FSM state encoding and PIO register map.
// RD_LVL/LVL_WAIT exist only when PIO_EVENT_MASTER_LEVEL_READ_EN is defined.
package pio_evt_pkg;

  localparam logic [1:0] PIO_ADDR_DATA = 2'd0;
  localparam logic [1:0] PIO_ADDR_MASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGE = 2'd3;

  typedef enum logic [2:0] {
    INIT_MASK = 3'd0,
    IDLE      = 3'd1,
    RD_CAP    = 3'd2,
    RD_WAIT   = 3'd3,
    WR_CLR    = 3'd4,
`ifdef PIO_EVENT_MASTER_LEVEL_READ_EN
    RD_LVL    = 3'd5,
    LVL_WAIT  = 3'd6,
`endif
    EMIT      = 3'd7
  } evt_state_t;

endpackage

// File: rtl/pio_event_master.sv
// Avalon-MM master that services a PIO edge-capture interrupt and turns it into a ready/valid event.
// Define PIO_EVENT_MASTER_LEVEL_READ_EN to also read the PIO data register into evt_levels.
module pio_event_master
  import pio_evt_pkg::*;
#(
  parameter int               WIDTH         = 5,
  parameter logic [WIDTH-1:0] IRQ_MASK_INIT = 5'h1F
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             irq,
  output logic [1:0]       avm_address,
  output logic             avm_chipselect,
  output logic             avm_write_n,
  output logic [31:0]      avm_writedata,
  input  logic [31:0]      avm_readdata,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_edges,
  output logic [WIDTH-1:0] evt_levels,
  output logic [7:0]       evt_seq,
  output logic             init_done
);

  evt_state_t       r_state;
  evt_state_t       w_next;
  logic [1:0]       r_address;
  logic             r_cs;
  logic             r_write_n;
  logic [31:0]      r_writedata;
  logic             r_init_done;
  logic             r_evt_valid;
  logic [WIDTH-1:0] r_edges;
  logic [7:0]       r_seq;

  logic [1:0]       w_address;
  logic             w_cs;
  logic             w_write_n;
  logic [31:0]      w_writedata;
  logic [WIDTH-1:0] w_rd_bits;
  logic             w_unused_rd;

  assign w_rd_bits   = avm_readdata[WIDTH-1:0];
  assign w_unused_rd = ^avm_readdata[31:WIDTH];

  // Bus signals are registered from the next state so they line up with the
  // state they belong to and come out of reset idle, as INIT_MASK is entered.
  always_comb begin
    w_next      = r_state;
    w_address   = PIO_ADDR_DATA;
    w_cs        = 1'b0;
    w_write_n   = 1'b1;
    w_writedata = '0;

    case (r_state)
      INIT_MASK: if (r_cs) w_next = IDLE;
      IDLE:      if (irq) w_next = RD_CAP;
      RD_CAP:    w_next = RD_WAIT;
      RD_WAIT:   w_next = (w_rd_bits == '0) ? IDLE : WR_CLR;
`ifdef PIO_EVENT_MASTER_LEVEL_READ_EN
      WR_CLR:    w_next = RD_LVL;
      RD_LVL:    w_next = LVL_WAIT;
      LVL_WAIT:  w_next = EMIT;
`else
      WR_CLR:    w_next = EMIT;
`endif
      EMIT:      if (evt_ready) w_next = IDLE;
      default:   w_next = INIT_MASK;
    endcase

    case (w_next)
      INIT_MASK: begin
        w_address   = PIO_ADDR_MASK;
        w_cs        = 1'b1;
        w_write_n   = 1'b0;
        w_writedata = 32'(IRQ_MASK_INIT);
      end
      RD_CAP: begin
        w_address = PIO_ADDR_EDGE;
        w_cs      = 1'b1;
      end
      RD_WAIT: begin
        w_address = PIO_ADDR_EDGE;
      end
      WR_CLR: begin
        // Clear only the bits just read so later edges remain pending.
        w_address   = PIO_ADDR_EDGE;
        w_cs        = 1'b1;
        w_write_n   = 1'b0;
        w_writedata = 32'(w_rd_bits);
      end
`ifdef PIO_EVENT_MASTER_LEVEL_READ_EN
      RD_LVL: begin
        w_address = PIO_ADDR_DATA;
        w_cs      = 1'b1;
      end
      LVL_WAIT: begin
        w_address = PIO_ADDR_DATA;
      end
`endif
      default: begin
        w_address = PIO_ADDR_DATA;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= INIT_MASK;
      r_address   <= PIO_ADDR_DATA;
      r_cs        <= 1'b0;
      r_write_n   <= 1'b1;
      r_writedata <= '0;
      r_init_done <= 1'b0;
      r_evt_valid <= 1'b0;
      r_edges     <= '0;
      r_seq       <= '0;
    end else begin
      r_state     <= w_next;
      r_address   <= w_address;
      r_cs        <= w_cs;
      r_write_n   <= w_write_n;
      r_writedata <= w_writedata;
      r_evt_valid <= (w_next == EMIT);
      if (r_state == INIT_MASK && w_next == IDLE) r_init_done <= 1'b1;
      if (r_state == RD_WAIT) r_edges <= w_rd_bits;
      if (r_state == EMIT && evt_ready) r_seq <= r_seq + 8'd1;
    end
  end

`ifdef PIO_EVENT_MASTER_LEVEL_READ_EN
  logic [WIDTH-1:0] r_levels;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_levels <= '0;
    end else if (r_state == LVL_WAIT) begin
      r_levels <= w_rd_bits;
    end
  end

  assign evt_levels = r_levels;
`else
  assign evt_levels = '0;
`endif

  assign avm_address    = r_address;
  assign avm_chipselect = r_cs;
  assign avm_write_n    = r_write_n;
  assign avm_writedata  = r_writedata;
  assign evt_valid      = r_evt_valid;
  assign evt_edges      = r_edges;
  assign evt_seq        = r_seq;
  assign init_done      = r_init_done;

endmodule
